// File: rtl/mux_scan_n.sv
// -----------------------------------------------------------------------------
// mux_scan_n
// Parametrised N:1 multiplexer (N = 2**SEL_W) with a registered output and a
// built-in channel sequencer. In manual mode the channel comes from S. In
// auto-scan mode the block steps through the channels enabled in MASK and holds
// each one for DWELL cycles.
//
// Ports
//   CLK      clock, all state changes on the rising edge
//   RST_BAR  synchronous active-low reset
//   EN_BAR   active-low enable (1 = block parked in IDLE)
//   MODE     0 = manual select, 1 = auto-scan
//   S        manual channel select
//   MASK     per-channel scan enable, bit i includes channel i
//   IN       packed channel data, channel i at IN[i*WIDTH +: WIDTH]
//   OUTPUT   registered data of the channel shown on CH
//   CH       channel currently driven on OUTPUT
//   VALID    OUTPUT carries channel data
//   WRAP     one-cycle pulse when the scan wraps back to the lowest channel
// -----------------------------------------------------------------------------
module mux_scan_n #(
   parameter int WIDTH = 1,
   parameter int SEL_W = 3,
   parameter int DWELL = 4
) (
   input  logic                          CLK,
   input  logic                          RST_BAR,
   input  logic                          EN_BAR,
   input  logic                          MODE,
   input  logic [SEL_W-1:0]              S,
   input  logic [(2**SEL_W)-1:0]         MASK,
   input  logic [(WIDTH*(2**SEL_W))-1:0] IN,
   output logic [WIDTH-1:0]              OUTPUT,
   output logic [SEL_W-1:0]              CH,
   output logic                          VALID,
   output logic                          WRAP
);

   localparam int N     = 2**SEL_W;
   localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_MANUAL = 2'd1,
      ST_SCAN   = 2'd2
   } state_t;

   state_t              state_r;
   state_t              state_nxt_s;
   logic [SEL_W-1:0]    ch_r;
   logic [SEL_W-1:0]    ch_nxt_s;
   logic [CNT_W-1:0]    cnt_r;
   logic [CNT_W-1:0]    cnt_nxt_s;
   logic [WIDTH-1:0]    out_r;
   logic [WIDTH-1:0]    out_nxt_s;
   logic                valid_r;
   logic                valid_nxt_s;
   logic                wrap_r;
   logic                wrap_nxt_s;

   logic [SEL_W-1:0]    first_ch_s;
   logic [SEL_W-1:0]    hop_ch_s;
   logic                hop_wrap_s;
   logic                mask_empty_s;
   logic                scan_entry_s;
   logic                dwell_done_s;

   // Data of channel idx taken from the packed input bus.
   function automatic logic [WIDTH-1:0] slice_of(
      input logic [(WIDTH*N)-1:0] data,
      input logic [SEL_W-1:0]     idx
   );
      logic [WIDTH-1:0] res;
      res = {WIDTH{1'b0}};
      for (int i = 0; i < N; i++) begin
         res = (SEL_W'(i) == idx) ? data[i*WIDTH +: WIDTH] : res;
      end
      return res;
   endfunction

   // Lowest set bit of mask (0 when mask is empty; callers guard that case).
   function automatic logic [SEL_W-1:0] lowest_set(input logic [N-1:0] mask);
      logic [SEL_W-1:0] lo;
      lo = {SEL_W{1'b0}};
      // Walking downwards leaves the smallest set index in lo.
      for (int i = N - 1; i >= 0; i--) begin
         lo = mask[i] ? SEL_W'(i) : lo;
      end
      return lo;
   endfunction

   // Next set bit strictly above cur; wraps to the lowest set bit otherwise.
   // Result is {wrapped, channel}.
   function automatic logic [SEL_W:0] next_set(
      input logic [N-1:0]     mask,
      input logic [SEL_W-1:0] cur
   );
      logic [SEL_W-1:0] above;
      logic             found;
      above = {SEL_W{1'b0}};
      found = 1'b0;
      // Walking downwards leaves the closest set bit above cur.
      for (int i = N - 1; i >= 0; i--) begin
         found = (mask[i] && (SEL_W'(i) > cur)) ? 1'b1 : found;
         above = (mask[i] && (SEL_W'(i) > cur)) ? SEL_W'(i) : above;
      end
      return found ? {1'b0, above} : {1'b1, lowest_set(mask)};
   endfunction

   assign first_ch_s               = lowest_set(MASK);
   assign {hop_wrap_s, hop_ch_s}   = next_set(MASK, ch_r);
   assign mask_empty_s             = (MASK == {N{1'b0}});
   // A scan (re)starts from the entry rule whenever we were not already
   // showing a scanned channel: arriving from IDLE/MANUAL, or the mask
   // having been empty on the previous cycle.
   assign scan_entry_s             = (state_r != ST_SCAN) || !valid_r;
   // The held channel is left early when its own mask bit disappears.
   assign dwell_done_s             = (cnt_r == CNT_LAST) || !MASK[ch_r];

   // Next-state and next-output decode.
   always_comb begin
      state_nxt_s = state_r;
      ch_nxt_s    = ch_r;
      cnt_nxt_s   = {CNT_W{1'b0}};
      out_nxt_s   = {WIDTH{1'b0}};
      valid_nxt_s = 1'b0;
      wrap_nxt_s  = 1'b0;

      if (EN_BAR) begin
         state_nxt_s = ST_IDLE;
      end else if (!MODE) begin
         state_nxt_s = ST_MANUAL;
      end else begin
         state_nxt_s = ST_SCAN;
      end

      case (state_nxt_s)
         ST_IDLE: begin
            ch_nxt_s = ch_r;
         end
         ST_MANUAL: begin
            ch_nxt_s    = S;
            out_nxt_s   = slice_of(IN, S);
            valid_nxt_s = 1'b1;
         end
         ST_SCAN: begin
            if (mask_empty_s) begin
               ch_nxt_s = ch_r;
            end else if (scan_entry_s) begin
               ch_nxt_s    = first_ch_s;
               out_nxt_s   = slice_of(IN, first_ch_s);
               valid_nxt_s = 1'b1;
            end else if (dwell_done_s) begin
               ch_nxt_s    = hop_ch_s;
               out_nxt_s   = slice_of(IN, hop_ch_s);
               valid_nxt_s = 1'b1;
               wrap_nxt_s  = hop_wrap_s;
            end else begin
               cnt_nxt_s   = cnt_r + CNT_W'(1'b1);
               out_nxt_s   = slice_of(IN, ch_r);
               valid_nxt_s = 1'b1;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // State and registered outputs, synchronous active-low reset.
   always_ff @(posedge CLK) begin
      if (!RST_BAR) begin
         state_r <= ST_IDLE;
         ch_r    <= {SEL_W{1'b0}};
         cnt_r   <= {CNT_W{1'b0}};
         out_r   <= {WIDTH{1'b0}};
         valid_r <= 1'b0;
         wrap_r  <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         ch_r    <= ch_nxt_s;
         cnt_r   <= cnt_nxt_s;
         out_r   <= out_nxt_s;
         valid_r <= valid_nxt_s;
         wrap_r  <= wrap_nxt_s;
      end
   end

   assign OUTPUT = out_r;
   assign CH     = ch_r;
   assign VALID  = valid_r;
   assign WRAP   = wrap_r;

endmodule

// File: tb/tb_mux_scan_n.sv
// -----------------------------------------------------------------------------
// tb_mux_scan_n
// Self-checking bench for mux_scan_n (WIDTH=1, SEL_W=3, DWELL=4). A behavioural
// model tracks the displayed channel and how long it has been shown, and picks
// the next channel by a rotating search over the mask.
// -----------------------------------------------------------------------------
module tb_mux_scan_n;

   localparam int W  = 1;
   localparam int SW = 3;
   localparam int N  = 8;
   localparam int DW = 4;

   logic              clk;
   logic              rst_bar;
   logic              en_bar;
   logic              mode;
   logic [SW-1:0]     s;
   logic [N-1:0]      mask;
   logic [W*N-1:0]    in_v;
   logic [W-1:0]      dut_out;
   logic [SW-1:0]     dut_ch;
   logic              dut_valid;
   logic              dut_wrap;

   int checks = 0;
   int errors = 0;

   // behavioural model: 0 = idle, 1 = manual, 2 = scan
   int            m_state;
   logic [SW-1:0] m_ch;
   int            m_age;
   logic [W-1:0]  m_out;
   logic          m_valid;
   logic          m_wrap;

   mux_scan_n #(.WIDTH(W), .SEL_W(SW), .DWELL(DW)) dut (
      .CLK    (clk),
      .RST_BAR(rst_bar),
      .EN_BAR (en_bar),
      .MODE   (mode),
      .S      (s),
      .MASK   (mask),
      .IN     (in_v),
      .OUTPUT (dut_out),
      .CH     (dut_ch),
      .VALID  (dut_valid),
      .WRAP   (dut_wrap)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Apply one clock edge to the model using the inputs present at the edge.
   task automatic model_tick();
      bit fresh;
      bit found;
      int c;
      int pick;
      m_wrap = 1'b0;
      if (!rst_bar) begin
         m_state = 0; m_ch = '0; m_age = 0; m_out = '0; m_valid = 1'b0;
      end else if (en_bar) begin
         m_state = 0; m_age = 0; m_out = '0; m_valid = 1'b0;
      end else if (!mode) begin
         m_state = 1; m_ch = s; m_age = 0; m_valid = 1'b1;
         m_out = in_v[s*W +: W];
      end else begin
         fresh   = (m_state != 2) || !m_valid;
         m_state = 2;
         if (mask == '0) begin
            m_valid = 1'b0; m_out = '0; m_age = 0;
         end else begin
            if (fresh) begin
               found = 1'b0;
               pick  = 0;
               for (int k = 0; k < N; k++) begin
                  if (!found && mask[k]) begin pick = k; found = 1'b1; end
               end
               m_ch  = SW'(pick);
               m_age = 1;
            end else if (!mask[m_ch] || m_age == DW) begin
               found = 1'b0;
               pick  = 0;
               for (int k = 1; k <= N; k++) begin
                  c = (int'(m_ch) + k) % N;
                  if (!found && mask[c]) begin pick = c; found = 1'b1; end
               end
               m_wrap = (pick <= int'(m_ch));
               m_ch   = SW'(pick);
               m_age  = 1;
            end else begin
               m_age = m_age + 1;
            end
            m_valid = 1'b1;
            m_out   = in_v[m_ch*W +: W];
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_tick();
      #1;
   endtask

   task automatic test_reset();
      rst_bar = 1'b0; en_bar = 1'b0; mode = 1'b0; s = 3'd3;
      mask = 8'hFF; in_v = 8'hAB;
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++;
         if ({dut_out, dut_ch, dut_valid, dut_wrap} !== 6'b0) begin
            errors++;
            $display("FAIL reset cyc=%0d: out=%h ch=%0d valid=%b wrap=%b, want all 0",
                     i, dut_out, dut_ch, dut_valid, dut_wrap);
         end
      end
      rst_bar = 1'b1; en_bar = 1'b1;
      for (int i = 0; i < N; i++) begin
         s = SW'(i);
         tick();
         checks++;
         if ({dut_out, dut_ch, dut_valid, dut_wrap} !== 6'b0) begin
            errors++;
            $display("FAIL disable s=%0d: out=%h ch=%0d valid=%b wrap=%b, want all 0",
                     i, dut_out, dut_ch, dut_valid, dut_wrap);
         end
      end
   endtask

   task automatic test_manual();
      logic exp_man [N] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      en_bar = 1'b0; mode = 1'b0; in_v = 8'hAB;
      for (int i = 0; i < N; i++) begin
         s = SW'(i);
         tick();
         checks++;
         if (dut_out !== exp_man[i] || dut_ch !== SW'(i) || dut_valid !== 1'b1 || dut_wrap !== 1'b0) begin
            errors++;
            $display("FAIL manual_sweep s=%0d: out=%b ch=%0d valid=%b wrap=%b, want out=%b ch=%0d valid=1 wrap=0",
                     i, dut_out, dut_ch, dut_valid, dut_wrap, exp_man[i], i);
         end
      end
      for (int i = 0; i < 24; i++) begin
         s = SW'($urandom_range(0, N - 1));
         in_v = 8'($urandom);
         mask = 8'($urandom);
         tick();
         checks++;
         if ({dut_out, dut_ch, dut_valid, dut_wrap} !== {m_out, m_ch, m_valid, m_wrap}) begin
            errors++;
            $display("FAIL manual_rand i=%0d: out=%b ch=%0d valid=%b wrap=%b, want out=%b ch=%0d valid=%b wrap=%b",
                     i, dut_out, dut_ch, dut_valid, dut_wrap, m_out, m_ch, m_valid, m_wrap);
         end
      end
   endtask

   task automatic test_full_scan();
      mode = 1'b1; mask = 8'hFF;
      for (int t = 0; t < 36; t++) begin
         in_v = 8'($urandom);
         s = SW'($urandom_range(0, N - 1));
         tick();
         checks++;
         if (dut_ch !== SW'((t / DW) % N) || dut_wrap !== (t == DW * N) ||
             dut_out !== in_v[dut_ch] || dut_valid !== 1'b1) begin
            errors++;
            $display("FAIL full_scan t=%0d: ch=%0d wrap=%b out=%b valid=%b, want ch=%0d wrap=%b out=%b valid=1",
                     t, dut_ch, dut_wrap, dut_out, dut_valid, (t / DW) % N, (t == DW * N), in_v[(t / DW) % N]);
         end
      end
   endtask

   task automatic test_sparse();
      int seq [3] = '{2, 5, 7};
      en_bar = 1'b1;
      tick();
      en_bar = 1'b0; mask = 8'b1010_0100;
      for (int t = 0; t < 26; t++) begin
         in_v = 8'($urandom);
         tick();
         checks++;
         if (dut_ch !== SW'(seq[(t / DW) % 3]) || dut_wrap !== (t > 0 && t % (3 * DW) == 0) ||
             {dut_out, dut_valid} !== {m_out, m_valid}) begin
            errors++;
            $display("FAIL sparse t=%0d: ch=%0d wrap=%b out=%b valid=%b, want ch=%0d wrap=%b out=%b valid=%b",
                     t, dut_ch, dut_wrap, dut_out, dut_valid, seq[(t / DW) % 3],
                     (t > 0 && t % (3 * DW) == 0), m_out, m_valid);
         end
      end
      en_bar = 1'b1;
      tick();
      en_bar = 1'b0; mask = 8'b0001_0000;
      for (int t = 0; t < 13; t++) begin
         in_v = 8'($urandom);
         tick();
         checks++;
         if (dut_ch !== 3'd4 || dut_wrap !== (t > 0 && t % DW == 0) || dut_out !== in_v[4]) begin
            errors++;
            $display("FAIL single_bit t=%0d: ch=%0d wrap=%b out=%b, want ch=4 wrap=%b out=%b",
                     t, dut_ch, dut_wrap, dut_out, (t > 0 && t % DW == 0), in_v[4]);
         end
      end
   endtask

   task automatic test_mask_edges();
      // continues from the single-bit scan parked on channel 4
      in_v = 8'hFF;
      mask = 8'h00;
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++;
         if (dut_valid !== 1'b0 || dut_out !== 1'b0 || dut_ch !== 3'd4 || dut_wrap !== 1'b0) begin
            errors++;
            $display("FAIL mask_zero i=%0d: valid=%b out=%b ch=%0d wrap=%b, want valid=0 out=0 ch=4 wrap=0",
                     i, dut_valid, dut_out, dut_ch, dut_wrap);
         end
      end
      mask = 8'h0C;
      tick();
      checks++;
      if (dut_ch !== 3'd2 || dut_valid !== 1'b1 || dut_out !== 1'b1 || dut_wrap !== 1'b0) begin
         errors++;
         $display("FAIL mask_restore: ch=%0d valid=%b out=%b wrap=%b, want ch=2 valid=1 out=1 wrap=0",
                  dut_ch, dut_valid, dut_out, dut_wrap);
      end
      tick();
      // counter now 1 on channel 2; drop channel 2 from the mask
      mask = 8'h08;
      for (int t = 0; t < 5; t++) begin
         in_v = 8'($urandom);
         tick();
         checks++;
         if (dut_ch !== 3'd3 || dut_wrap !== (t == DW) || {dut_out, dut_valid} !== {m_out, m_valid}) begin
            errors++;
            $display("FAIL clear_current t=%0d: ch=%0d wrap=%b out=%b valid=%b, want ch=3 wrap=%b out=%b valid=%b",
                     t, dut_ch, dut_wrap, dut_out, dut_valid, (t == DW), m_out, m_valid);
         end
      end
   endtask

   task automatic test_reset_mid_scan();
      en_bar = 1'b1;
      tick();
      en_bar = 1'b0; mode = 1'b1; mask = 8'hFF;
      for (int t = 0; t <= 22; t++) begin
         in_v = 8'($urandom);
         tick();
      end
      checks++;
      if (dut_ch !== 3'd5) begin
         errors++;
         $display("FAIL pre_reset_ch: ch=%0d, want 5", dut_ch);
      end
      rst_bar = 1'b0;
      tick();
      checks++;
      if ({dut_out, dut_ch, dut_valid, dut_wrap} !== 6'b0) begin
         errors++;
         $display("FAIL reset_mid_scan: out=%b ch=%0d valid=%b wrap=%b, want all 0",
                  dut_out, dut_ch, dut_valid, dut_wrap);
      end
      rst_bar = 1'b1;
      for (int t = 0; t < 6; t++) begin
         in_v = 8'($urandom);
         tick();
         checks++;
         if (dut_ch !== SW'(t / DW) || dut_valid !== 1'b1 || dut_wrap !== 1'b0 || dut_out !== in_v[t / DW]) begin
            errors++;
            $display("FAIL restart t=%0d: ch=%0d valid=%b wrap=%b out=%b, want ch=%0d valid=1 wrap=0 out=%b",
                     t, dut_ch, dut_valid, dut_wrap, dut_out, t / DW, in_v[t / DW]);
         end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 2000; i++) begin
         rst_bar = ($urandom_range(0, 99) != 0);
         if ($urandom_range(0, 15) == 0) en_bar = ~en_bar;
         if ($urandom_range(0, 19) == 0) mode = ~mode;
         if ($urandom_range(0, 5) == 0) begin
            case ($urandom_range(0, 3))
               0:       mask = 8'h00;
               1:       mask = 8'(32'd1 << $urandom_range(0, N - 1));
               default: mask = 8'($urandom);
            endcase
         end
         s    = SW'($urandom_range(0, N - 1));
         in_v = 8'($urandom);
         tick();
         checks++;
         if ({dut_out, dut_ch, dut_valid, dut_wrap} !== {m_out, m_ch, m_valid, m_wrap}) begin
            errors++;
            $display("FAIL random i=%0d: out=%b ch=%0d valid=%b wrap=%b, want out=%b ch=%0d valid=%b wrap=%b",
                     i, dut_out, dut_ch, dut_valid, dut_wrap, m_out, m_ch, m_valid, m_wrap);
         end
      end
   endtask

   initial begin
      m_state = 0; m_ch = '0; m_age = 0; m_out = '0; m_valid = 1'b0; m_wrap = 1'b0;
      test_reset();
      test_manual();
      test_full_scan();
      test_sparse();
      test_mask_edges();
      test_reset_mid_scan();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mux_scan_n.md
Name: mux_scan_n

Overview:
Parametrised N:1 multiplexer with a registered output and a built-in channel sequencer. It supersedes the fixed 8:1 combinational mux and adds two features: a per-channel data width, and an auto-scan mode. In auto-scan mode the block steps through the enabled channels, holding each one for a programmable dwell time. It sits between a bank of sampled signal sources and a single downstream sink (probe, serialiser or logger).

Parameters:
WIDTH, 1, bits per channel.
SEL_W, 3, select width; channel count N = 2**SEL_W.
DWELL, 4, cycles spent on each channel in scan mode (must be at least 1).

Ports:
CLK  input  1  clock; all state updates on the rising edge.
RST_BAR  input  1  reset, synchronous, active-low.
EN_BAR  input  1  enable, active-low; 1 = block disabled.
MODE  input  1  0 = manual select, 1 = auto-scan.
S  input  SEL_W  manual channel select.
MASK  input  N  per-channel scan enable; bit i = 1 includes channel i in the scan.
IN  input  WIDTH*N  packed channel data; channel i occupies IN[i*WIDTH +: WIDTH].
OUTPUT  output  WIDTH  registered selected data.
CH  output  SEL_W  channel currently driven on OUTPUT.
VALID  output  1  OUTPUT holds valid channel data.
WRAP  output  1  one-cycle pulse when the scan wraps around.

Behaviour:
- Reset (RST_BAR=0 at a clock edge): OUTPUT=0, CH=0, VALID=0, WRAP=0, dwell counter=0, state=IDLE. Reset overrides every other input, including in the middle of a scan.
- States: IDLE, MANUAL, SCAN. The next state is evaluated every cycle:
  - EN_BAR=1 → IDLE;
  - otherwise MODE=0 → MANUAL;
  - otherwise MODE=1 → SCAN.
- IDLE:
  - OUTPUT=0, VALID=0, WRAP=0.
  - CH holds its value; dwell counter is cleared.
- MANUAL:
  - Each cycle, OUTPUT <= IN slice[S] and CH <= S; VALID=1.
  - Latency is 1 cycle from a change on S or IN to OUTPUT.
  - MASK is ignored and WRAP is held at 0.
- SCAN entry (from IDLE or MANUAL):
  - CH <= lowest-index set bit of MASK; counter <= 0.
  - OUTPUT <= data of that channel; VALID=1.
- SCAN steady state:
  - OUTPUT <= IN slice[CH] every cycle, so it tracks live data on the held channel.
  - The counter increments each cycle. When counter = DWELL-1: counter <= 0, and CH <= next set MASK bit above CH, searching in increasing index order.
  - If no set bit lies above CH, the search wraps to the lowest set bit and WRAP=1 for exactly that one cycle.
- Single set MASK bit: CH does not change; WRAP pulses once every DWELL cycles.
- MASK all zero while in SCAN: VALID=0, OUTPUT=0, CH holds, counter held at 0. When a bit becomes set, the block behaves as a fresh SCAN entry on the next cycle.
- Current CH cleared in MASK mid-dwell: on the next edge, advance to the next set bit (with wrap/WRAP rules) and reset the counter. The dwell time is not completed.
- DWELL=1: CH advances every cycle.
- MODE or EN_BAR change: takes effect at the next edge. Returning to SCAN always goes through the entry rule; dwell progress is not resumed.
- Counter width is clog2(DWELL), minimum 1 bit.
- All outputs are registered; there is no combinational path from inputs to outputs.

Test Plan:
1. Reset and disable: SEL_W=3, WIDTH=1, IN=8'hAB, RST_BAR=0 for 2 cycles, then EN_BAR=1 for all S values 0..7 → OUTPUT=0, VALID=0, CH=0 throughout.
2. Manual sweep: EN_BAR=0, MODE=0, S stepped 0..7 with one value per cycle → OUTPUT equals 1,1,0,1,0,1,0,1, each one cycle after its S value; CH follows S with a 1-cycle delay; VALID=1.
3. Full scan: MODE=1, MASK=8'hFF, DWELL=4 → CH holds 0 for 4 cycles, then 1, …, 7. On the cycle after CH=7's dwell, CH=0 and WRAP=1 for one cycle; OUTPUT matches IN bit CH each cycle.
4. Sparse mask: MASK=8'b1010_0100 → CH sequence 2,5,7,2…; WRAP asserts only on the 7→2 transition. Then MASK=8'b0001_0000 → CH stays 4 and WRAP pulses every 4 cycles.
5. Mask edge cases:
   - MASK changed to 0 mid-scan → next cycle VALID=0, OUTPUT=0, CH held.
   - MASK restored to 8'h0C → CH=2, VALID=1.
   - Clearing the current channel's bit at counter=1 → CH advances on the next edge and the counter restarts.
6. Reset mid-scan: assert RST_BAR=0 while CH=5 with counter=2 → next edge gives OUTPUT=0, CH=0, VALID=0, WRAP=0. After release with MODE=1, MASK=8'hFF → scan restarts at CH=0 with a full 4-cycle dwell.
